// File: rtl/anc_sequencer.sv
// anc_sequencer: drives LP -> ERR -> (LMS) -> FIR start strobes per ambient sample.
// Optional per-stage watchdog is enabled by defining ANC_SEQ_WATCHDOG_EN.
module anc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sample_ready_in,
  input  logic       adapt_en_in,
  input  logic       clear_in,
  input  logic       lp_done_in,
  input  logic       err_done_in,
  input  logic       lms_done_in,
  input  logic       fir_done_in,
  output logic       lp_start_out,
  output logic       err_start_out,
  output logic       lms_start_out,
  output logic       fir_start_out,
  output logic       busy_out,
  output logic       frame_done_out,
  output logic [7:0] overrun_count_out,
  output logic       fault_out,
  output logic [1:0] fault_stage_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LP, S_ERR, S_LMS, S_FIR
  } state_t;

  state_t state_q;
  state_t state_nxt;
  state_t state_d;
  logic   lp_go, err_go, lms_go, fir_go;
  logic   done_go, accept, overrun, timeout;

  assign busy_out = (state_q != S_IDLE);

  // A done strobe is ignored while its own start strobe is still high.
  always_comb begin
    state_nxt = state_q;
    lp_go     = 1'b0;
    err_go    = 1'b0;
    lms_go    = 1'b0;
    fir_go    = 1'b0;
    done_go   = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_ready_in) begin
          state_nxt = S_LP;
          lp_go     = 1'b1;
          accept    = 1'b1;
        end
      end
      S_LP: begin
        if (lp_done_in && !lp_start_out) begin
          state_nxt = S_ERR;
          err_go    = 1'b1;
        end
      end
      S_ERR: begin
        if (err_done_in && !err_start_out) begin
          if (adapt_en_in) begin
            state_nxt = S_LMS;
            lms_go    = 1'b1;
          end else begin
            state_nxt = S_FIR;
            fir_go    = 1'b1;
          end
        end
      end
      S_LMS: begin
        if (lms_done_in && !lms_start_out) begin
          state_nxt = S_FIR;
          fir_go    = 1'b1;
        end
      end
      S_FIR: begin
        if (fir_done_in && !fir_start_out) begin
          done_go = 1'b1;
          if (sample_ready_in) begin
            state_nxt = S_LP;
            lp_go     = 1'b1;
            accept    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_d = timeout ? S_IDLE : state_nxt;
  assign overrun = sample_ready_in && busy_out && !accept;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      lp_start_out   <= 1'b0;
      err_start_out  <= 1'b0;
      lms_start_out  <= 1'b0;
      fir_start_out  <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      state_q        <= state_d;
      lp_start_out   <= lp_go;
      err_start_out  <= err_go;
      lms_start_out  <= lms_go;
      fir_start_out  <= fir_go;
      frame_done_out <= done_go;
    end
  end

  // Clear acts before the increment, so clear plus overrun yields 1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_count_out <= 8'd0;
    end else if (clear_in) begin
      overrun_count_out <= overrun ? 8'd1 : 8'd0;
    end else if (overrun && overrun_count_out != 8'hFF) begin
      overrun_count_out <= overrun_count_out + 8'd1;
    end
  end

`ifdef ANC_SEQ_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q;
  logic [1:0]  stage_code;
  logic        fault_q;
  logic [1:0]  fault_stage_q;

  assign timeout = busy_out && (state_nxt == state_q) &&
                   (wd_cnt_q == WdLast);

  always_comb begin
    stage_code = 2'd0;
    unique case (state_q)
      S_ERR:   stage_code = 2'd1;
      S_LMS:   stage_code = 2'd2;
      S_FIR:   stage_code = 2'd3;
      default: stage_code = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_cnt_q <= 16'd0;
    end else if (state_d != state_q || state_d == S_IDLE) begin
      wd_cnt_q <= 16'd0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fault_q       <= 1'b0;
      fault_stage_q <= 2'd0;
    end else if (timeout) begin
      fault_q       <= 1'b1;
      fault_stage_q <= stage_code;
    end else if (clear_in) begin
      fault_q <= 1'b0;
    end
  end

  assign fault_out       = fault_q;
  assign fault_stage_out = fault_stage_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign timeout         = 1'b0;
  assign fault_out       = 1'b0;
  assign fault_stage_out = 2'd0;
`endif

endmodule

// File: tb/tb_anc_sequencer.sv
// tb_anc_sequencer: timeline-planned random frames, scoreboarded strobes.
// Covers watchdog behaviour with and without ANC_SEQ_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_anc_sequencer;
  localparam int MAXC = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sr_i = 1'b0, ad_i = 1'b0, clr_i = 1'b0;
  logic       lpd_i = 1'b0, erd_i = 1'b0, lmd_i = 1'b0, fid_i = 1'b0;
  logic       lp_s, err_s, lms_s, fir_s, busy, fdone, fault;
  logic [7:0] cnt;
  logic [1:0] fstage;

  anc_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .sample_ready_in(sr_i), .adapt_en_in(ad_i), .clear_in(clr_i),
    .lp_done_in(lpd_i), .err_done_in(erd_i),
    .lms_done_in(lmd_i), .fir_done_in(fid_i),
    .lp_start_out(lp_s), .err_start_out(err_s),
    .lms_start_out(lms_s), .fir_start_out(fir_s),
    .busy_out(busy), .frame_done_out(fdone),
    .overrun_count_out(cnt), .fault_out(fault),
    .fault_stage_out(fstage)
  );

  always #5 clk = ~clk;

  // Stimulus per clock edge index; expectations per cycle after that edge.
  bit         a_sr[MAXC], a_acc[MAXC], a_ad[MAXC], a_clr[MAXC];
  bit         a_lpd[MAXC], a_erd[MAXC], a_lmd[MAXC], a_fid[MAXC];
  bit         a_rst[MAXC];
  int         a_to[MAXC];
  logic [4:0] a_ev[MAXC];
  bit         e_busy[MAXC], e_fault[MAXC];
  int         e_cnt[MAXC], e_stage[MAXC];

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  localparam logic [4:0] EV_LP = 5'b00001, EV_ERR = 5'b00010;
  localparam logic [4:0] EV_LMS = 5'b00100, EV_FIR = 5'b01000;
  localparam logic [4:0] EV_DONE = 5'b10000;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic fill_busy(input int lo, input int hi);
    for (int x = lo; x <= hi; x++) e_busy[x] = 1'b1;
  endtask

  task automatic add_ovr(input int lo, input int hi, input int pct);
    for (int x = lo; x <= hi; x++)
      if (rnd(0, 99) < pct) a_sr[x] = 1'b1;
  endtask

  // mode 0: full frame, 1: ERR done withheld, 2: reset one cycle into LMS
  task automatic plan_frame(input int a, input int dl, input int de,
                            input int dm, input int df, input bit ad,
                            input int ovr, input int mode,
                            output int last);
    int s;
    a_sr[a] = 1'b1;
    a_acc[a] = 1'b1;
    a_ev[a] |= EV_LP;
    if (rnd(0, 1) == 1) a_lpd[a+1] = 1'b1;
    for (int x = a + 1; x < a + dl; x++)
      if (rnd(0, 3) == 0) a_fid[x] = 1'b1;
    s = a + dl;
    a_lpd[s] = 1'b1;
    a_ev[s] |= EV_ERR;
    if (rnd(0, 1) == 1) a_erd[s+1] = 1'b1;
    if (mode == 1) begin
`ifdef ANC_SEQ_WATCHDOG_EN
      last = s + 16;
      a_to[last] = 2;
`else
      last = s + 40;
      a_rst[last] = 1'b1;
`endif
      fill_busy(a, last - 1);
      add_ovr(a + 1, last - 1, ovr);
      return;
    end
    if (!ad)
      for (int x = s + 1; x < s + de; x++)
        if (rnd(0, 2) == 0) a_lmd[x] = 1'b1;
    s = s + de;
    a_erd[s] = 1'b1;
    a_ad[s] = ad;
    if (ad) begin
      a_ev[s] |= EV_LMS;
      if (mode == 2) begin
        last = s + 1;
        a_rst[last] = 1'b1;
        fill_busy(a, s);
        add_ovr(a + 1, s, ovr);
        return;
      end
      s = s + dm;
      a_lmd[s] = 1'b1;
    end
    a_ev[s] |= EV_FIR;
    last = s + df;
    a_fid[last] = 1'b1;
    a_ev[last] |= EV_DONE;
    fill_busy(a, last - 1);
    add_ovr(a + 1, last - 1, ovr);
  endtask

  always @(negedge clk) begin
    logic [4:0] v;
    ev_t        ev;
    if (mon_on) begin
      v = {fdone, fir_s, lms_s, err_s, lp_s};
      chk("busy", int'(busy), int'(e_busy[cyc]));
      chk("overrun_count", int'(cnt), e_cnt[cyc]);
      chk("fault", int'(fault), int'(e_fault[cyc]));
      chk("fault_stage", int'(fstage), e_stage[cyc]);
      if (v != 5'd0) begin
        if (q.size() == 0) begin
          chk("strobe_unexpected", int'(v), 0);
        end else begin
          ev = q.pop_front();
          chk("strobe_cycle", cyc, ev.cyc);
          chk("strobe_vec", int'(v), int'(ev.v));
        end
      end else if (q.size() != 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        chk("strobe_missing", 0, int'(ev.v));
      end
    end
  end

  initial begin
    int t, e, l, t_end, cntm, sm;
    bit fm;
    for (int x = 0; x < MAXC; x++) a_ad[x] = (rnd(0, 1) == 1);

    t = 2;
    plan_frame(t, 3, 3, 3, 3, 1'b1, 0, 0, e);
    t = e + 3;
    plan_frame(t, 3, 3, 3, 3, 1'b0, 0, 0, e);
    t = e;
    plan_frame(t, rnd(2, 6), rnd(2, 6), rnd(2, 6), rnd(2, 6),
               1'b1, 0, 0, e);
    repeat (12) begin
      t = e + rnd(0, 2);
      plan_frame(t, rnd(2, 8), rnd(2, 8), rnd(2, 8), rnd(2, 8),
                 (rnd(0, 1) == 1), 20, 0, e);
    end
    t = e + 2;
    repeat (10) begin
      plan_frame(t, 8, 8, 8, 8, 1'b1, 100, 0, e);
      t = e;
    end
    a_clr[e+2] = 1'b1;
    t = e + 4;
    plan_frame(t, 4, 4, 4, 4, 1'b1, 100, 0, e);
    a_clr[t+5] = 1'b1;
    t = e + 2;
    plan_frame(t, 3, 5, 3, 3, 1'b1, 10, 1, l);
`ifdef ANC_SEQ_WATCHDOG_EN
    a_clr[l+3] = 1'b1;
    t = l + 5;
`else
    t = l + 2;
`endif
    plan_frame(t, 3, 3, 4, 3, 1'b1, 10, 2, l);
    t = l + 1;
    plan_frame(t, 3, 3, 3, 3, 1'b1, 0, 0, e);
    repeat (4) begin
      t = e + rnd(0, 2);
      plan_frame(t, rnd(2, 8), rnd(2, 8), rnd(2, 8), rnd(2, 8),
                 (rnd(0, 1) == 1), 30, 0, e);
    end
    t_end = e + 4;

    cntm = 0;
    fm = 1'b0;
    sm = 0;
    for (int x = 1; x <= t_end; x++) begin
      if (a_clr[x]) begin
        cntm = 0;
        fm = 1'b0;
      end
      if (a_sr[x] && e_busy[x-1] && !a_acc[x])
        cntm = (cntm < 255) ? cntm + 1 : 255;
      if (a_to[x] != 0) begin
        fm = 1'b1;
        sm = a_to[x] - 1;
      end
      if (a_rst[x]) begin
        cntm = 0;
        fm = 1'b0;
        sm = 0;
      end
      e_cnt[x] = cntm;
      e_fault[x] = fm;
      e_stage[x] = sm;
      if (a_ev[x] != 5'd0) q.push_back('{cyc: x, v: a_ev[x]});
    end

    #1 rst = 1'b1;
    #1 chk("reset_outputs", int'({fdone, fir_s, lms_s, err_s, lp_s,
                                  busy, fault, fstage, cnt}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    mon_on = 1'b1;

    for (int x = 1; x <= t_end; x++) begin
      sr_i  = a_sr[x];
      ad_i  = a_ad[x];
      clr_i = a_clr[x];
      lpd_i = a_lpd[x];
      erd_i = a_erd[x];
      lmd_i = a_lmd[x];
      fid_i = a_fid[x];
      @(posedge clk);
      #1 cyc = x;
      if (a_rst[x]) begin
        #2 rst = 1'b1;
        #1 chk("async_reset", int'({fdone, fir_s, lms_s, err_s, lp_s,
                                    busy, fault, fstage, cnt}), 0);
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    #1 mon_on = 1'b0;
    chk("events_left", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
